// File: rtl/immediate_generation_pkg.sv
// Shared encodings for the registered immediate generator: immediate select
// codes and the M/K skid-buffer state.
package immediate_generation_pkg;

  localparam logic [2:0] IMM_U     = 3'b000;
  localparam logic [2:0] IMM_J     = 3'b001;
  localparam logic [2:0] IMM_I     = 3'b010;
  localparam logic [2:0] IMM_B     = 3'b011;
  localparam logic [2:0] IMM_S     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_NONE  = 3'b111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/immediate_decode.sv
// Combinational immediate decoder, XLEN 32 or 64. Build macro IMMGEN_ZIMM_EN
// enables the CSR zimm select; without it that select decodes to zero.
module immediate_decode #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  input  logic [2:0]      select,
  output logic [XLEN-1:0] imm
);
  import immediate_generation_pkg::*;

  logic [31:0] imm32;
  logic        sign_ext;
  logic        sign_bit;
  logic        unused_bits;

  // Signed types are built already sign-extended to 32 bits; the XLEN=64
  // widening then only needs bit 31 for those types.
  always_comb begin
    imm32    = '0;
    sign_ext = 1'b1;
    case (select)
      IMM_U: imm32 = {instruction[31:12], 12'b0};
      IMM_J: imm32 = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                      instruction[30:21], 1'b0};
      IMM_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
      IMM_B: imm32 = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                      instruction[4:1], 1'b0};
      IMM_S: imm32 = {{21{instruction[31]}}, instruction[30:25], instruction[11:7]};
      IMM_SHAMT: begin
        sign_ext = 1'b0;
        imm32    = (XLEN == 64) ? {26'b0, instruction[25:20]} : {27'b0, instruction[24:20]};
      end
`ifdef IMMGEN_ZIMM_EN
      IMM_ZIMM: begin
        sign_ext = 1'b0;
        imm32    = {27'b0, instruction[19:15]};
      end
`endif
      default: imm32 = '0;
    endcase
  end

  assign sign_bit    = sign_ext & imm32[31];
  assign unused_bits = ^{instruction[6:5], instruction[0]};

  if (XLEN == 64) begin : g_xlen64
    assign imm = {{32{sign_bit}}, imm32};
  end else if (XLEN == 32) begin : g_xlen32
    logic unused_sign;
    assign unused_sign = sign_bit;
    assign imm         = imm32;
  end else begin : g_bad_xlen
    $error("immediate_decode: XLEN must be 32 or 64");
  end

endmodule

// File: rtl/immediate_generation_pipe.sv
// Registered valid/ready immediate generator with a 2-entry (M + skid K)
// buffer and synchronous flush. Optional build macro: IMMGEN_ZIMM_EN.
module immediate_generation_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      INSTRUCTION,
  input  logic [2:0]       SELECT,
  input  logic [TAG_W-1:0] TAG_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  IMM_OUT,
  output logic [TAG_W-1:0] TAG_OUT
);
  import immediate_generation_pkg::*;

  buf_state_t       state_q, state_d;
  logic [XLEN-1:0]  dec_imm;
  logic [XLEN-1:0]  m_imm, k_imm;
  logic [TAG_W-1:0] m_tag, k_tag;
  logic             accept, take;
  logic             load_m, load_k, move_k;

  immediate_decode #(.XLEN(XLEN)) u_decode (
    .instruction (INSTRUCTION),
    .select      (SELECT),
    .imm         (dec_imm)
  );

  // Both handshake outputs decode the state register only, so ready never
  // depends combinationally on OUT_READY.
  assign IN_READY  = (state_q != FULL);
  assign OUT_VALID = (state_q != EMPTY);
  assign accept    = IN_VALID && IN_READY;
  assign take      = OUT_VALID && OUT_READY;

  always_comb begin
    state_d = state_q;
    load_m  = 1'b0;
    load_k  = 1'b0;
    move_k  = 1'b0;
    if (FLUSH) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          load_m  = 1'b1;
        end
        ONE: begin
          if (accept && take) begin
            load_m = 1'b1;
          end else if (accept) begin
            state_d = FULL;
            load_k  = 1'b1;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        FULL: if (take) begin
          state_d = ONE;
          move_k  = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // M feeds the outputs directly; K only holds the entry that arrived while M stalled.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_imm <= '0;
      m_tag <= '0;
      k_imm <= '0;
      k_tag <= '0;
    end else begin
      if (load_m) begin
        m_imm <= dec_imm;
        m_tag <= TAG_IN;
      end else if (move_k) begin
        m_imm <= k_imm;
        m_tag <= k_tag;
      end
      if (load_k) begin
        k_imm <= dec_imm;
        k_tag <= TAG_IN;
      end
    end
  end

  assign IMM_OUT = m_imm;
  assign TAG_OUT = m_tag;

endmodule

// File: tb/tb_immediate_generation_pipe.sv
// Self-checking bench: drives one stimulus into an XLEN=32 and an XLEN=64
// instance and checks both against constants and a FIFO reference model.
module tb_immediate_generation_pipe;
  import immediate_generation_pkg::*;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             out_ready;
  logic [31:0]      inst;
  logic [2:0]       sel;
  logic [TAG_W-1:0] tag_in;

  logic             rdy32, vld32, rdy64, vld64;
  logic [31:0]      imm32;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag32, tag64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  immediate_generation_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .CLK(clk), .RESET_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(rdy32),
    .INSTRUCTION(inst), .SELECT(sel), .TAG_IN(tag_in), .OUT_VALID(vld32),
    .OUT_READY(out_ready), .IMM_OUT(imm32), .TAG_OUT(tag32)
  );

  immediate_generation_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .CLK(clk), .RESET_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(rdy64),
    .INSTRUCTION(inst), .SELECT(sel), .TAG_IN(tag_in), .OUT_VALID(vld64),
    .OUT_READY(out_ready), .IMM_OUT(imm64), .TAG_OUT(tag64)
  );

  typedef struct {
    logic [31:0]      inst;
    logic [2:0]       sel;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp32;
    logic [63:0]      exp64;
  } vec_t;

  typedef struct {
    logic [31:0]      e32;
    logic [63:0]      e64;
    logic [TAG_W-1:0] tag;
  } exp_t;

  vec_t vecs[10];
  exp_t model_q[$];

  // Reference immediate built from bit weights of the instruction fields.
  function automatic logic [63:0] refImm(logic [31:0] i, logic [2:0] s, int xlen);
    longint v;
    v = 0;
    case (s)
      3'd0: v = longint'($signed(i[31:12])) * 4096;
      3'd1: v = -longint'(i[31]) * (1 << 20) + longint'(i[19:12]) * 4096
                + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      3'd2: v = longint'($signed(i[31:20]));
      3'd3: v = -longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                + longint'(i[30:25]) * 32 + longint'(i[4:1]) * 2;
      3'd4: v = -longint'(i[31]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:7]);
      3'd5: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
`ifdef IMMGEN_ZIMM_EN
      3'd6: v = longint'(i[19:15]);
`endif
      default: v = 0;
    endcase
    if (xlen == 32) return {32'b0, v[31:0]};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBoth(input string name, input logic [31:0] e32, input logic [63:0] e64,
                           input logic [TAG_W-1:0] etag);
    checkOutput({name, " valid32"}, vld32, 1);
    checkOutput({name, " valid64"}, vld64, 1);
    checkOutput({name, " imm32"}, imm32, e32);
    checkOutput({name, " imm64"}, imm64, e64);
    checkOutput({name, " tag32"}, tag32, etag);
    checkOutput({name, " tag64"}, tag64, etag);
  endtask

  task automatic checkHandshake(input string name, input logic ev, input logic er);
    checkOutput({name, " out_valid32"}, vld32, ev);
    checkOutput({name, " out_valid64"}, vld64, ev);
    checkOutput({name, " in_ready32"}, rdy32, er);
    checkOutput({name, " in_ready64"}, rdy64, er);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [2:0] s,
                               input logic [TAG_W-1:0] t, input logic r, input logic f);
    @(negedge clk);
    in_valid  = v;
    inst      = i;
    sel       = s;
    tag_in    = t;
    out_ready = r;
    flush     = f;
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h53a4c063, IMM_U,     5'd1,  32'h53a4c000, 64'h0000000053a4c000};
    vecs[1] = '{32'hdaee306f, IMM_J,     5'd2,  32'hfffe35ae, 64'hfffffffffffe35ae};
    vecs[2] = '{32'hfe800013, IMM_I,     5'd3,  32'hffffffe8, 64'hffffffffffffffe8};
    vecs[3] = '{32'h940000fb, IMM_B,     5'd4,  32'hfffff95a, 64'hfffffffffffff95a};
    vecs[4] = '{32'h94000523, IMM_S,     5'd5,  32'hfffff94a, 64'hfffffffffffff94a};
    vecs[5] = '{32'h80000037, IMM_U,     5'd6,  32'h80000000, 64'hffffffff80000000};
    vecs[6] = '{32'h03f00013, IMM_SHAMT, 5'd7,  32'h0000001f, 64'h000000000000003f};
`ifdef IMMGEN_ZIMM_EN
    vecs[7] = '{32'h000d8073, IMM_ZIMM,  5'd8,  32'h0000001b, 64'h000000000000001b};
`else
    vecs[7] = '{32'h000d8073, IMM_ZIMM,  5'd8,  32'h00000000, 64'h0000000000000000};
`endif
    vecs[8] = '{32'hffffffff, IMM_NONE,  5'd9,  32'h00000000, 64'h0000000000000000};
    vecs[9] = '{32'h00000013, IMM_I,     5'd31, 32'h00000000, 64'h0000000000000000};

    rst_n = 1'b0;
    {in_valid, out_ready, flush} = '0;
    inst = '0; sel = '0; tag_in = '0;
    repeat (2) @(negedge clk);
    #1;
    checkHandshake("reset", 0, 1);
    checkOutput("reset imm64", imm64, 0);
    checkOutput("reset tag32", tag32, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back table vectors, each result one cycle after its accept.
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) applyStimulus(1, vecs[i].inst, vecs[i].sel, vecs[i].tag, 1, 0);
      else        applyStimulus(0, 32'h0, 3'd0, 5'd0, 1, 0);
      checkOutput("table in_ready32", rdy32, 1);
      checkOutput("table in_ready64", rdy64, 1);
      if (i == 0) checkOutput("table first out_valid", vld32, 0);
      else checkBoth($sformatf("table[%0d]", i - 1), vecs[i-1].exp32, vecs[i-1].exp64, vecs[i-1].tag);
    end
    applyStimulus(0, 32'h0, 3'd0, 5'd0, 1, 0);
    checkHandshake("table drained", 0, 1);

    // Back-pressure: tags 1 and 2 buffered, tag 3 held upstream until space frees.
    applyStimulus(1, vecs[2].inst, IMM_I, 5'd1, 0, 0);
    checkHandshake("bp empty", 0, 1);
    applyStimulus(1, vecs[4].inst, IMM_S, 5'd2, 0, 0);
    checkHandshake("bp one", 1, 1);
    checkBoth("bp one", 32'hffffffe8, 64'hffffffffffffffe8, 5'd1);
    applyStimulus(1, vecs[0].inst, IMM_U, 5'd3, 0, 0);
    checkHandshake("bp full", 1, 0);
    checkBoth("bp full stable", 32'hffffffe8, 64'hffffffffffffffe8, 5'd1);
    applyStimulus(1, vecs[0].inst, IMM_U, 5'd3, 1, 0);
    checkHandshake("bp drain1", 1, 0);
    checkBoth("bp drain1", 32'hffffffe8, 64'hffffffffffffffe8, 5'd1);
    applyStimulus(1, vecs[0].inst, IMM_U, 5'd3, 1, 0);
    checkHandshake("bp drain2", 1, 1);
    checkBoth("bp drain2", 32'hfffff94a, 64'hfffffffffffff94a, 5'd2);
    applyStimulus(0, 32'h0, 3'd0, 5'd0, 1, 0);
    checkBoth("bp drain3", 32'h53a4c000, 64'h0000000053a4c000, 5'd3);
    applyStimulus(0, 32'h0, 3'd0, 5'd0, 1, 0);
    checkHandshake("bp idle", 0, 1);

    // Flush in FULL with a valid input, then flush beating an accept in EMPTY.
    applyStimulus(1, vecs[2].inst, IMM_I, 5'd11, 0, 0);
    applyStimulus(1, vecs[4].inst, IMM_S, 5'd12, 0, 0);
    applyStimulus(1, vecs[0].inst, IMM_U, 5'd13, 0, 1);
    checkHandshake("flush at full", 1, 0);
    applyStimulus(1, vecs[5].inst, IMM_U, 5'd14, 1, 1);
    checkHandshake("after flush", 0, 1);
    applyStimulus(1, vecs[6].inst, IMM_SHAMT, 5'd15, 1, 0);
    checkHandshake("flush dropped input", 0, 1);
    applyStimulus(0, 32'h0, 3'd0, 5'd0, 1, 0);
    checkBoth("post flush", 32'h1f, 64'h3f, 5'd15);
    applyStimulus(0, 32'h0, 3'd0, 5'd0, 1, 0);
    checkHandshake("post flush idle", 0, 1);

    // Asynchronous reset while FULL takes effect before the next rising edge.
    applyStimulus(1, vecs[2].inst, IMM_I, 5'd4, 0, 0);
    applyStimulus(1, vecs[4].inst, IMM_S, 5'd5, 0, 0);
    applyStimulus(0, 32'h0, 3'd0, 5'd0, 0, 0);
    checkHandshake("pre reset full", 1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    checkHandshake("async reset", 0, 1);
    checkOutput("async reset imm32", imm32, 0);
    checkOutput("async reset imm64", imm64, 0);
    checkOutput("async reset tag64", tag64, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, vecs[1].inst, IMM_J, 5'd6, 1, 0);
    checkHandshake("post reset accept", 0, 1);
    applyStimulus(0, 32'h0, 3'd0, 5'd0, 1, 0);
    checkBoth("post reset", 32'hfffe35ae, 64'hfffffffffffe35ae, 5'd6);
    applyStimulus(0, 32'h0, 3'd0, 5'd0, 1, 0);
    checkHandshake("post reset idle", 0, 1);

    // Random traffic against a capacity-2 FIFO model.
    model_q.delete();
    for (int c = 0; c < 600; c++) begin
      logic             v, r, f, acc, tk;
      logic [31:0]      ri;
      logic [2:0]       rs;
      logic [TAG_W-1:0] rt;
      exp_t             e;
      v  = 1'($urandom_range(0, 3) != 0);
      r  = 1'($urandom_range(0, 2) != 0);
      f  = 1'($urandom_range(0, 31) == 0);
      ri = $urandom;
      rs = 3'($urandom_range(0, 7));
      rt = TAG_W'($urandom);
      applyStimulus(v, ri, rs, rt, r, f);
      checkHandshake("rand", model_q.size() > 0, model_q.size() < 2);
      if (model_q.size() > 0) begin
        checkOutput("rand imm32", imm32, model_q[0].e32);
        checkOutput("rand imm64", imm64, model_q[0].e64);
        checkOutput("rand tag32", tag32, model_q[0].tag);
        checkOutput("rand tag64", tag64, model_q[0].tag);
      end
      acc = v && (model_q.size() < 2);
      tk  = r && (model_q.size() > 0);
      if (f) begin
        model_q.delete();
      end else begin
        if (tk) void'(model_q.pop_front());
        if (acc) begin
          e.e32 = refImm(ri, rs, 32)[31:0];
          e.e64 = refImm(ri, rs, 64);
          e.tag = rt;
          model_q.push_back(e);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
